// File: rtl/pll_ad_pkg.sv
// Shared types and widths for the ADC sample-clock PLL controller.
package pll_ad_pkg;

  localparam int unsigned CntWidth  = 16;
  localparam int unsigned OdivWidth = 7;

  typedef logic [CntWidth-1:0]  cnt_t;
  typedef logic [OdivWidth-1:0] odiv_t;

  typedef enum logic [2:0] {
    StPrst   = 3'd0,
    StWlock  = 3'd1,
    StStab   = 3'd2,
    StRun    = 3'd3,
    StGate   = 3'd4,
    StReconf = 3'd5,
    StFault  = 3'd6
  } state_e;

endpackage

// File: rtl/pll_ad_ctrl_if.sv
// Divider-change request/acknowledge port of the PLL controller.
interface pll_ad_ctrl_if;
  import pll_ad_pkg::*;

  logic  cfg_req;
  odiv_t cfg_odiv;
  logic  cfg_ack;
  logic  cfg_err;

  modport master (output cfg_req, output cfg_odiv, input cfg_ack, input cfg_err);
  modport slave  (input cfg_req, input cfg_odiv, output cfg_ack, output cfg_err);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous status inputs.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);
  logic [Width-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_ad_ctrl.sv
// ADC sample-clock PLL sequencer: reset/lock/stability sequencing, run-time divider
// reconfiguration through the cfg port, and bounded-retry relock on lock loss.
module pll_ad_ctrl
  import pll_ad_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 64,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned GATE_CYCLES   = 8,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned ODIV_INIT     = 5
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         pll_lock,
  output logic         pll_rst,
  output logic         pll_enclk0,
  output odiv_t        pll_odsel0,
  output logic         clk_ready,
  pll_ad_ctrl_if.slave cfg,
  output logic         busy,
  output logic         fault,
  input  logic         fault_clr,
  output logic [7:0]   relock_cnt,
  output logic [2:0]   state_o
);
  localparam cnt_t       RstLast     = cnt_t'(RST_CYCLES - 1);
  localparam cnt_t       TimeoutLast = cnt_t'(LOCK_TIMEOUT - 1);
  localparam cnt_t       StableLast  = cnt_t'(STABLE_CYCLES - 1);
  localparam cnt_t       GateLast    = cnt_t'(GATE_CYCLES - 1);
  localparam logic [3:0] MaxRetry    = 4'(MAX_RETRY);
  localparam odiv_t      OdivInit    = odiv_t'(ODIV_INIT);

  logic       lock_s;
  state_e     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [3:0] retry_q, retry_d;
  logic       pend_q, pend_d, done_q, done_d;
  odiv_t      odiv_lat_q, odiv_lat_d, odsel_q, odsel_d;
  logic       ack_q, ack_d, err_q, err_d;
  logic [7:0] relock_q, relock_d;
  logic       rst_q, rst_d, run_q, run_d, busy_q, busy_d, fault_q, fault_d;

  sync_2ff #(.Width(1)) u_lock_sync (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .d    (pll_lock),
    .q    (lock_s)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + cnt_t'(1);
    retry_d    = retry_q;
    pend_d     = pend_q;
    done_d     = done_q & cfg.cfg_req;
    odiv_lat_d = odiv_lat_q;
    odsel_d    = odsel_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    relock_d   = relock_q;

    unique case (state_q)
      StPrst: begin
        if (cnt_q == RstLast) begin
          state_d = StWlock;
          cnt_d   = '0;
        end
      end
      StWlock: begin
        if (lock_s) begin
          state_d = StStab;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          retry_d = retry_q + 4'd1;
          cnt_d   = '0;
          state_d = (retry_d == MaxRetry) ? StFault : StPrst;
        end
      end
      StStab: begin
        if (!lock_s) begin
          state_d = StWlock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          retry_d = '0;
        end
      end
      StRun: begin
        cnt_d = '0;
        // Lock loss has priority; an unaccepted request is simply retried next RUN.
        if (!lock_s) begin
          state_d = StGate;
          if (relock_q != 8'hff) relock_d = relock_q + 8'd1;
        end else if (cfg.cfg_req && !done_q) begin
          if (cfg.cfg_odiv == '0) begin
            ack_d  = 1'b1;
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            pend_d     = 1'b1;
            odiv_lat_d = cfg.cfg_odiv;
            state_d    = StGate;
          end
        end
      end
      StGate: begin
        if (cnt_q == GateLast) begin
          state_d = StReconf;
          cnt_d   = '0;
        end
      end
      StReconf: begin
        state_d = StPrst;
        cnt_d   = '0;
        if (pend_q) odsel_d = odiv_lat_q;
      end
      StFault: begin
        cnt_d = '0;
        if (fault_clr) begin
          retry_d = '0;
          state_d = StPrst;
        end else if (cfg.cfg_req && !done_q) begin
          ack_d  = 1'b1;
          err_d  = 1'b1;
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = StPrst;
        cnt_d   = '0;
      end
    endcase

    if (pend_q && (state_d == StRun || state_d == StFault)) begin
      ack_d  = 1'b1;
      err_d  = (state_d == StFault);
      pend_d = 1'b0;
      done_d = 1'b1;
    end

    rst_d   = state_d inside {StPrst, StReconf, StFault};
    run_d   = (state_d == StRun);
    busy_d  = !(state_d inside {StRun, StFault});
    fault_d = (state_d == StFault);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StPrst;
      cnt_q      <= '0;
      retry_q    <= '0;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
      odiv_lat_q <= OdivInit;
      odsel_q    <= OdivInit;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      relock_q   <= '0;
      rst_q      <= 1'b1;
      run_q      <= 1'b0;
      busy_q     <= 1'b1;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      odiv_lat_q <= odiv_lat_d;
      odsel_q    <= odsel_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      relock_q   <= relock_d;
      rst_q      <= rst_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
    end
  end

  assign pll_rst     = rst_q;
  assign pll_enclk0  = run_q;
  assign clk_ready   = run_q;
  assign pll_odsel0  = odsel_q;
  assign busy        = busy_q;
  assign fault       = fault_q;
  assign relock_cnt  = relock_q;
  assign state_o     = state_q;
  assign cfg.cfg_ack = ack_q;
  assign cfg.cfg_err = err_q;

endmodule
